// File: rtl/stopwatch_pkg.sv
// Shared types and BCD limits for the stopwatch counter and its bench.
// The FSM state type is also exposed on the top-level debug port.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    PAUSED = 2'd1,
    ADJUST = 2'd2
  } state_t;

  localparam logic [3:0] ONES_MAX     = 4'd9;
  localparam logic [3:0] SEC_TENS_MAX = 4'd5;
  localparam int         MAX_MIN_DEFAULT = 99;

  // Split a decimal value (0..99) into its BCD tens and ones digits.
  function automatic logic [3:0] tens_digit(input int value);
    return 4'(value / 10);
  endfunction

  function automatic logic [3:0] ones_digit(input int value);
    return 4'(value % 10);
  endfunction

  localparam logic [3:0] MAX_MIN_TENS_DEFAULT = tens_digit(MAX_MIN_DEFAULT);
  localparam logic [3:0] MAX_MIN_ONES_DEFAULT = ones_digit(MAX_MIN_DEFAULT);

endpackage

// File: rtl/edge_pulse.sv
// Rising-edge detector for a slow level that is already synchronous to clk_100MHz.
// Reset loads the current level so a level that is high at release does not fire.
module edge_pulse (
  input  logic clk_100MHz,
  input  logic rst,
  input  logic level,
  output logic pulse
);

  logic level_q;

  always_ff @(posedge clk_100MHz) begin
    if (rst) begin
      level_q <= level;
    end else begin
      level_q <= level;
    end
  end

  assign pulse = level & ~level_q;

endmodule

// File: rtl/stopwatch_counter.sv
// MM:SS stopwatch with run/pause/adjust control and BCD display digits.
// pause_p is a one-cycle pulse with no handshake: it acts on the edge that samples it.
module stopwatch_counter
  import stopwatch_pkg::*;
#(
  parameter int MAX_MIN = MAX_MIN_DEFAULT
) (
  input  logic       clk_100MHz,
  input  logic       rst,
  input  logic       clk_1Hz,
  input  logic       clk_2Hz,
  input  logic       clk_adjust,
  input  logic       pause_p,
  input  logic       adj,
  input  logic       sel,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       running,
  output logic       blank_min,
  output logic       blank_sec,
  output state_t     state_dbg
);

  localparam logic [3:0] MIN_TENS_MAX = tens_digit(MAX_MIN);
  localparam logic [3:0] MIN_ONES_MAX = ones_digit(MAX_MIN);

  state_t     state;
  state_t     state_next;
  logic       tick1;
  logic       tick2;
  logic       inc_sec;
  logic       inc_min;
  logic       sec_at_max;
  logic       min_at_max;
  logic [3:0] min_tens_n;
  logic [3:0] min_ones_n;
  logic [3:0] sec_tens_n;
  logic [3:0] sec_ones_n;

  edge_pulse u_edge_1hz (
    .clk_100MHz (clk_100MHz),
    .rst        (rst),
    .level      (clk_1Hz),
    .pulse      (tick1)
  );

  edge_pulse u_edge_2hz (
    .clk_100MHz (clk_100MHz),
    .rst        (rst),
    .level      (clk_2Hz),
    .pulse      (tick2)
  );

  // adj wins over pause_p; pause_p has no effect while adjusting.
  always_comb begin
    state_next = state;
    case (state)
      RUN: begin
        if (adj)          state_next = ADJUST;
        else if (pause_p) state_next = PAUSED;
      end
      PAUSED: begin
        if (adj)          state_next = ADJUST;
        else if (pause_p) state_next = RUN;
      end
      ADJUST: begin
        if (!adj)         state_next = PAUSED;
      end
      default: state_next = RUN;
    endcase
  end

  assign sec_at_max = (sec_tens == SEC_TENS_MAX) && (sec_ones == ONES_MAX);
  assign min_at_max = (min_tens == MIN_TENS_MAX) && (min_ones == MIN_ONES_MAX);

  // Counting uses the current state, so a tick1 that coincides with pause_p still counts.
  // Only RUN lets the seconds roll over into minutes.
  always_comb begin
    inc_sec = 1'b0;
    inc_min = 1'b0;
    case (state)
      RUN: begin
        if (tick1) begin
          inc_sec = 1'b1;
          inc_min = sec_at_max;
        end
      end
      ADJUST: begin
        if (tick2) begin
          inc_sec = sel;
          inc_min = ~sel;
        end
      end
      default: begin
        inc_sec = 1'b0;
        inc_min = 1'b0;
      end
    endcase
  end

  always_comb begin
    sec_tens_n = sec_tens;
    sec_ones_n = sec_ones;
    min_tens_n = min_tens;
    min_ones_n = min_ones;

    if (inc_sec) begin
      if (sec_at_max) begin
        sec_tens_n = 4'd0;
        sec_ones_n = 4'd0;
      end else if (sec_ones == ONES_MAX) begin
        sec_tens_n = sec_tens + 4'd1;
        sec_ones_n = 4'd0;
      end else begin
        sec_ones_n = sec_ones + 4'd1;
      end
    end

    if (inc_min) begin
      if (min_at_max) begin
        min_tens_n = 4'd0;
        min_ones_n = 4'd0;
      end else if (min_ones == ONES_MAX) begin
        min_tens_n = min_tens + 4'd1;
        min_ones_n = 4'd0;
      end else begin
        min_ones_n = min_ones + 4'd1;
      end
    end
  end

  // Status outputs are loaded from state_next so they line up with the state register.
  always_ff @(posedge clk_100MHz) begin
    if (rst) begin
      state     <= RUN;
      min_tens  <= 4'd0;
      min_ones  <= 4'd0;
      sec_tens  <= 4'd0;
      sec_ones  <= 4'd0;
      running   <= 1'b1;
      blank_min <= 1'b0;
      blank_sec <= 1'b0;
    end else begin
      state     <= state_next;
      min_tens  <= min_tens_n;
      min_ones  <= min_ones_n;
      sec_tens  <= sec_tens_n;
      sec_ones  <= sec_ones_n;
      running   <= (state_next == RUN);
      blank_min <= (state_next == ADJUST) & ~sel & clk_adjust;
      blank_sec <= (state_next == ADJUST) &  sel & clk_adjust;
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Bench for stopwatch_counter: a decimal time model feeds an expected queue of
// {digits, running, state} words that is drained as the DUT outputs are sampled.
module tb_stopwatch_counter;
  import stopwatch_pkg::*;

  localparam int MAX_MIN = 99;
  localparam int W = 19;

  logic       clk_100MHz = 1'b0;
  logic       rst        = 1'b1;
  logic       clk_1Hz    = 1'b0;
  logic       clk_2Hz    = 1'b0;
  logic       clk_adjust = 1'b0;
  logic       pause_p    = 1'b0;
  logic       adj        = 1'b0;
  logic       sel        = 1'b0;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic       running, blank_min, blank_sec;
  state_t     state_dbg;

  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  int     m_min = 0;
  int     m_sec = 0;
  state_t m_state = RUN;

  stopwatch_counter #(.MAX_MIN(MAX_MIN)) dut (
    .clk_100MHz (clk_100MHz),
    .rst        (rst),
    .clk_1Hz    (clk_1Hz),
    .clk_2Hz    (clk_2Hz),
    .clk_adjust (clk_adjust),
    .pause_p    (pause_p),
    .adj        (adj),
    .sel        (sel),
    .min_tens   (min_tens),
    .min_ones   (min_ones),
    .sec_tens   (sec_tens),
    .sec_ones   (sec_ones),
    .running    (running),
    .blank_min  (blank_min),
    .blank_sec  (blank_sec),
    .state_dbg  (state_dbg)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk_100MHz = ~clk_100MHz;

  initial begin
    #5ms;
    $display("FAIL watchdog: bench did not reach its summary within 5 ms");
    $fatal(1, "watchdog expired");
  end

  // ---------------- model ----------------
  function automatic logic [W-1:0] model_word();
    return {4'(m_min / 10), 4'(m_min % 10), 4'(m_sec / 10), 4'(m_sec % 10),
            (m_state == RUN), m_state};
  endfunction

  function automatic logic [W-1:0] dut_word();
    return {min_tens, min_ones, sec_tens, sec_ones, running, state_dbg};
  endfunction

  task automatic model_run_second();
    m_sec = m_sec + 1;
    if (m_sec == 60) begin
      m_sec = 0;
      m_min = (m_min == MAX_MIN) ? 0 : m_min + 1;
    end
  endtask

  // ---------------- drivers (all called at a negedge) ----------------
  task automatic pulse_1hz();
    clk_1Hz = 1'b1;
    @(negedge clk_100MHz);
    clk_1Hz = 1'b0;
    @(negedge clk_100MHz);
  endtask

  task automatic pulse_2hz();
    clk_2Hz = 1'b1;
    @(negedge clk_100MHz);
    clk_2Hz = 1'b0;
    @(negedge clk_100MHz);
  endtask

  // Leaves the DUT in ADJUST showing mm:ss; the model tracks the adjust steps.
  task automatic preload(input int mm, input int ss);
    int n;
    adj = 1'b1;
    sel = 1'b0;
    @(negedge clk_100MHz);
    m_state = ADJUST;
    n = (mm - m_min + MAX_MIN + 1) % (MAX_MIN + 1);
    repeat (n) pulse_2hz();
    m_min = mm;
    sel = 1'b1;
    n = (ss - m_sec + 60) % 60;
    repeat (n) pulse_2hz();
    m_sec = ss;
  endtask

  task automatic leave_to_run();
    adj = 1'b0;
    @(negedge clk_100MHz);
    pause_p = 1'b1;
    @(negedge clk_100MHz);
    pause_p = 1'b0;
    m_state = RUN;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [W-1:0] e;
    clk_1Hz = 1'b1;
    rst = 1'b1;
    repeat (2) @(negedge clk_100MHz);
    rst = 1'b0;
    m_min = 0; m_sec = 0; m_state = RUN;
    exp_q.push_back(model_word());
    repeat (3) @(negedge clk_100MHz);
    e = exp_q.pop_front(); n_cmp++;
    if (dut_word() !== e) begin n_err++; $display("FAIL reset_no_extra_count got=%h exp=%h", dut_word(), e); end
    n_cmp++;
    if ({blank_min, blank_sec} !== 2'b00) begin n_err++; $display("FAIL reset_blank got=%b exp=00", {blank_min, blank_sec}); end

    clk_1Hz = 1'b0;
    @(negedge clk_100MHz);
    clk_1Hz = 1'b1;
    model_run_second();
    exp_q.push_back(model_word());
    @(negedge clk_100MHz);
    e = exp_q.pop_front(); n_cmp++;
    if (dut_word() !== e) begin n_err++; $display("FAIL tick1_latency got=%h exp=%h", dut_word(), e); end
    clk_1Hz = 1'b0;
    @(negedge clk_100MHz);
    repeat (2) begin pulse_1hz(); model_run_second(); end
    exp_q.push_back(model_word());
    e = exp_q.pop_front(); n_cmp++;
    if (dut_word() !== e) begin n_err++; $display("FAIL reset_then_3_ticks got=%h exp=%h", dut_word(), e); end
  endtask

  task automatic test_carry();
    logic [W-1:0] e;
    int pre_m[3] = '{0, 9, 99};
    int pre_s[3] = '{9, 59, 59};
    for (int i = 0; i < 3; i++) begin
      preload(pre_m[i], pre_s[i]);
      leave_to_run();
      pulse_1hz();
      model_run_second();
      exp_q.push_back(model_word());
      e = exp_q.pop_front(); n_cmp++;
      if (dut_word() !== e) begin n_err++; $display("FAIL carry_%0d got=%h exp=%h", i, dut_word(), e); end
    end
  endtask

  task automatic test_pause_same_cycle();
    logic [W-1:0] e;
    preload(0, 5);
    leave_to_run();
    clk_1Hz = 1'b1;
    pause_p = 1'b1;
    model_run_second();
    m_state = PAUSED;
    exp_q.push_back(model_word());
    @(negedge clk_100MHz);
    clk_1Hz = 1'b0;
    pause_p = 1'b0;
    e = exp_q.pop_front(); n_cmp++;
    if (dut_word() !== e) begin n_err++; $display("FAIL pause_with_tick got=%h exp=%h", dut_word(), e); end
    @(negedge clk_100MHz);
    repeat (5) pulse_1hz();
    exp_q.push_back(model_word());
    e = exp_q.pop_front(); n_cmp++;
    if (dut_word() !== e) begin n_err++; $display("FAIL paused_hold got=%h exp=%h", dut_word(), e); end
  endtask

  task automatic test_adjust();
    logic [W-1:0] e;
    preload(12, 58);
    exp_q.push_back(model_word());
    e = exp_q.pop_front(); n_cmp++;
    if (dut_word() !== e) begin n_err++; $display("FAIL adjust_preload got=%h exp=%h", dut_word(), e); end
    repeat (2) begin pulse_2hz(); m_sec = (m_sec + 1) % 60; end
    exp_q.push_back(model_word());
    e = exp_q.pop_front(); n_cmp++;
    if (dut_word() !== e) begin n_err++; $display("FAIL adjust_sec_no_carry got=%h exp=%h", dut_word(), e); end
    pulse_1hz();
    sel = 1'b0;
    repeat (3) @(negedge clk_100MHz);
    exp_q.push_back(model_word());
    e = exp_q.pop_front(); n_cmp++;
    if (dut_word() !== e) begin n_err++; $display("FAIL adjust_ignore_tick1_sel got=%h exp=%h", dut_word(), e); end
    repeat (88) begin pulse_2hz(); m_min = (m_min + 1) % (MAX_MIN + 1); end
    exp_q.push_back(model_word());
    e = exp_q.pop_front(); n_cmp++;
    if (dut_word() !== e) begin n_err++; $display("FAIL adjust_min_wrap got=%h exp=%h", dut_word(), e); end
  endtask

  task automatic test_blink();
    logic [W-1:0] e;
    sel = 1'b0;
    clk_adjust = 1'b1;
    #1;
    n_cmp++;
    if ({blank_min, blank_sec} !== 2'b00) begin n_err++; $display("FAIL blink_registered got=%b exp=00", {blank_min, blank_sec}); end
    @(negedge clk_100MHz);
    n_cmp++;
    if ({blank_min, blank_sec} !== 2'b10) begin n_err++; $display("FAIL blink_min_on got=%b exp=10", {blank_min, blank_sec}); end
    clk_adjust = 1'b0;
    @(negedge clk_100MHz);
    n_cmp++;
    if ({blank_min, blank_sec} !== 2'b00) begin n_err++; $display("FAIL blink_min_off got=%b exp=00", {blank_min, blank_sec}); end
    sel = 1'b1;
    clk_adjust = 1'b1;
    @(negedge clk_100MHz);
    n_cmp++;
    if ({blank_min, blank_sec} !== 2'b01) begin n_err++; $display("FAIL blink_sec_on got=%b exp=01", {blank_min, blank_sec}); end
    adj = 1'b0;
    m_state = PAUSED;
    exp_q.push_back(model_word());
    @(negedge clk_100MHz);
    e = exp_q.pop_front(); n_cmp++;
    if (dut_word() !== e) begin n_err++; $display("FAIL adjust_exit_paused got=%h exp=%h", dut_word(), e); end
    n_cmp++;
    if ({blank_min, blank_sec} !== 2'b00) begin n_err++; $display("FAIL blink_outside_adjust got=%b exp=00", {blank_min, blank_sec}); end
    clk_adjust = 1'b0;
  endtask

  task automatic test_reset_mid_adjust();
    logic [W-1:0] e;
    preload(45, 30);
    clk_adjust = 1'b1;
    exp_q.push_back(model_word());
    e = exp_q.pop_front(); n_cmp++;
    if (dut_word() !== e) begin n_err++; $display("FAIL preload_45_30 got=%h exp=%h", dut_word(), e); end
    rst = 1'b1;
    clk_2Hz = 1'b1;
    m_min = 0; m_sec = 0; m_state = RUN;
    exp_q.push_back(model_word());
    @(negedge clk_100MHz);
    e = exp_q.pop_front(); n_cmp++;
    if (dut_word() !== e) begin n_err++; $display("FAIL reset_mid_adjust got=%h exp=%h", dut_word(), e); end
    n_cmp++;
    if ({blank_min, blank_sec} !== 2'b00) begin n_err++; $display("FAIL reset_mid_adjust_blank got=%b exp=00", {blank_min, blank_sec}); end
    rst = 1'b0;
    adj = 1'b0;
    clk_adjust = 1'b0;
    repeat (2) @(negedge clk_100MHz);
    clk_2Hz = 1'b0;
    @(negedge clk_100MHz);
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] e;
    int n;
    preload(0, 55);
    leave_to_run();
    for (int it = 0; it < 6; it++) begin
      n = $urandom_range(1, 8);
      repeat (n) begin
        clk_2Hz = $urandom_range(0, 1);
        pulse_1hz();
        model_run_second();
      end
      clk_2Hz = 1'b0;
      repeat ($urandom_range(0, 3)) @(negedge clk_100MHz);
      exp_q.push_back(model_word());
      e = exp_q.pop_front(); n_cmp++;
      if (dut_word() !== e) begin n_err++; $display("FAIL back_to_back_%0d got=%h exp=%h", it, dut_word(), e); end
    end
  endtask

  initial begin
    @(negedge clk_100MHz);
    test_reset();
    test_carry();
    test_pause_same_cycle();
    test_adjust();
    test_blink();
    test_reset_mid_adjust();
    test_back_to_back();
    n_cmp++;
    if (exp_q.size() !== 0) begin n_err++; $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
